// File: rtl/cmd_fifo_reader_if.sv
// rtl/cmd_fifo_reader_if.sv - command valid/ready bus from the FIFO reader to the memory controller
interface cmd_fifo_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16,
  parameter int LEN_W  = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [MASK_W-1:0] cmd_wmask;
  logic [LEN_W-1:0]  cmd_len;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/cmd_fifo_reader.sv
// rtl/cmd_fifo_reader.sv - pops command FIFO words and presents them through a 2-entry buffer
module cmd_fifo_reader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16,
  parameter int LEN_W  = 2,
  parameter int CMD_W  = 179,
  parameter int CNT_W  = 16
) (
  input  logic                      clk_100MHz,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      fifo_empty,
  input  logic [CMD_W-1:0]          fifo_q,
  output logic                      fifo_rden,
  cmd_fifo_reader_if.master         cmd,
  output logic [CNT_W-1:0]          cmd_cnt,
  output logic                      busy
);

  // head drives the outputs; tail is the second buffered word
  logic [CMD_W-1:0] head;
  logic [CMD_W-1:0] tail;
  logic [1:0]       occ;
  logic             inflight;
  logic             pop;
  logic [2:0]       level;

  assign pop   = cmd.cmd_valid & cmd.cmd_ready;
  assign level = {1'b0, occ} + {2'b00, inflight};

  // Read only if the word will have a free slot when it lands; a pop this
  // cycle frees one. rstn gating keeps RdEn low while the block is held in reset.
  assign fifo_rden = rstn & en & ~fifo_empty & (level < (3'd2 + {2'b00, pop}));

  assign cmd.cmd_valid = (occ != 2'd0);
  assign busy          = (occ != 2'd0) | inflight;

  assign cmd.cmd_we    = head[CMD_W-1];
  assign cmd.cmd_addr  = head[CMD_W-2 -: ADDR_W];
  assign cmd.cmd_wdata = head[LEN_W+MASK_W +: DATA_W];
  assign cmd.cmd_wmask = head[LEN_W +: MASK_W];
  assign cmd.cmd_len   = head[LEN_W-1:0];

  // Buffer update: shift on pop, capture the in-flight Q into the next free slot
  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      head     <= '0;
      tail     <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      cmd_cnt  <= '0;
    end else begin
      inflight <= fifo_rden;
      if (pop) begin
        cmd_cnt <= cmd_cnt + CNT_W'(1);
      end
      case ({pop, inflight})
        2'b11: begin
          if (occ == 2'd1) begin
            head <= fifo_q;
          end else begin
            head <= tail;
            tail <= fifo_q;
          end
        end
        2'b10: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) begin
            head <= fifo_q;
          end else begin
            tail <= fifo_q;
          end
          occ <= occ + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_fifo_reader.sv
// tb/tb_cmd_fifo_reader.sv - directed scoreboard bench for cmd_fifo_reader
module tb_cmd_fifo_reader;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int LEN_W  = 2;
  localparam int CMD_W  = 179;
  localparam int CNT_W  = 16;

  logic              clk_100MHz = 1'b0;
  logic              rstn = 1'b0;
  logic              en = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [CMD_W-1:0]  fifo_q = '0;
  logic              fifo_rden;
  logic [CNT_W-1:0]  cmd_cnt;
  logic              busy;
  logic              hold_empty = 1'b0;
  logic              underflow = 1'b0;

  cmd_fifo_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .LEN_W(LEN_W)) cmd_if ();

  cmd_fifo_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
    .LEN_W(LEN_W), .CMD_W(CMD_W), .CNT_W(CNT_W)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rstn       (rstn),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rden  (fifo_rden),
    .cmd        (cmd_if),
    .cmd_cnt    (cmd_cnt),
    .busy       (busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  logic [CMD_W-1:0] cur_word;
  assign cur_word = {cmd_if.cmd_we, cmd_if.cmd_addr, cmd_if.cmd_wdata, cmd_if.cmd_wmask, cmd_if.cmd_len};

  logic [CMD_W-1:0] fq[$];
  logic [CMD_W-1:0] sb[$];

  // Standard-read FIFO model: Q updates the edge after RdEn
  always @(posedge clk_100MHz) begin
    if (fifo_rden) begin
      if (fq.size() == 0) underflow <= 1'b1;
      else fifo_q <= fq.pop_front();
    end
  end

  // Empty flag follows the queue shortly after each edge
  always begin
    @(posedge clk_100MHz);
    #2;
    fifo_empty = (fq.size() == 0) || hold_empty;
  end

  int checks = 0;
  int errors = 0;
  int rden_cnt = 0;
  int xfer_cnt = 0;
  int cyc = 0;
  int first_x = -1;
  int last_x = -1;
  logic s_rden = 1'b0;
  logic prev_hold = 1'b0;
  logic [CMD_W-1:0] prev_word = '0;

  task automatic chk(input string tag, input logic [CMD_W-1:0] obs, input logic [CMD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input int i);
    logic [31:0] v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [MASK_W-1:0] m;
    logic [LEN_W-1:0] l;
    v = i;
    a = 32'h2000_0000 | (v << 4);
    d = {v, ~v, v * 32'd3, 32'h5A5A_0000 + v};
    m = 16'h00FF ^ v[15:0];
    l = v[1:0];
    return {v[0], a, d, m, l};
  endfunction

  task automatic push(input logic [CMD_W-1:0] w);
    fq.push_back(w);
    sb.push_back(w);
  endtask

  // One clock: sample at negedge, score transfers, check hold stability
  task automatic cycle();
    logic [CMD_W-1:0] exp_w;
    @(negedge clk_100MHz);
    cyc++;
    s_rden = fifo_rden;
    if (fifo_rden) rden_cnt++;
    if (fifo_rden && fifo_empty) chk("rden_while_empty", CMD_W'(1), CMD_W'(0));
    if (prev_hold) begin
      chk("hold_valid", CMD_W'(cmd_if.cmd_valid), CMD_W'(1));
      chk("hold_word", cur_word, prev_word);
    end
    if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", cur_word, '0);
      end else begin
        exp_w = sb.pop_front();
        chk("xfer_word", cur_word, exp_w);
      end
      xfer_cnt++;
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    prev_hold = cmd_if.cmd_valid && !cmd_if.cmd_ready;
    prev_word = cur_word;
    @(posedge clk_100MHz);
    #1;
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    push({1'b1, 32'h0000_1000, {16{8'hA5}}, 16'hFFFF, 2'd2});
    repeat (4) cycle();
    chk("rst_rden", CMD_W'(s_rden), CMD_W'(0));
    chk("rst_valid", CMD_W'(cmd_if.cmd_valid), CMD_W'(0));
    chk("rst_cnt", CMD_W'(cmd_cnt), CMD_W'(0));
    chk("rst_busy", CMD_W'(busy), CMD_W'(0));

    // single command with exact latency
    rstn = 1'b1;
    cycle();
    chk("rden_after_release", CMD_W'(s_rden), CMD_W'(1));
    chk("valid_k", CMD_W'(cmd_if.cmd_valid), CMD_W'(0));
    chk("busy_inflight", CMD_W'(busy), CMD_W'(1));
    cycle();
    chk("valid_k1", CMD_W'(cmd_if.cmd_valid), CMD_W'(1));
    chk("f_we", CMD_W'(cmd_if.cmd_we), CMD_W'(1));
    chk("f_addr", CMD_W'(cmd_if.cmd_addr), CMD_W'(32'h0000_1000));
    chk("f_wdata", CMD_W'(cmd_if.cmd_wdata), CMD_W'({16{8'hA5}}));
    chk("f_wmask", CMD_W'(cmd_if.cmd_wmask), CMD_W'(16'hFFFF));
    chk("f_len", CMD_W'(cmd_if.cmd_len), CMD_W'(2'd2));
    cmd_if.cmd_ready = 1'b1;
    cycle();
    chk("single_cnt", CMD_W'(cmd_cnt), CMD_W'(1));
    chk("single_valid_off", CMD_W'(cmd_if.cmd_valid), CMD_W'(0));
    chk("single_busy", CMD_W'(busy), CMD_W'(0));

    // streaming 10 words, ready held high
    xfer_cnt = 0; first_x = -1; last_x = -1;
    for (int i = 0; i < 10; i++) push(mk(i));
    for (int n = 0; n < 40 && xfer_cnt < 10; n++) cycle();
    chk("stream_xfers", CMD_W'(xfer_cnt), CMD_W'(10));
    chk("stream_no_bubble", CMD_W'(last_x - first_x), CMD_W'(9));
    repeat (2) cycle();
    chk("stream_cnt", CMD_W'(cmd_cnt), CMD_W'(11));
    chk("stream_busy", CMD_W'(busy), CMD_W'(0));
    chk("stream_sb_empty", CMD_W'(sb.size()), CMD_W'(0));

    // back-pressure: 5 queued, ready low
    cmd_if.cmd_ready = 1'b0;
    rden_cnt = 0; xfer_cnt = 0;
    for (int i = 0; i < 5; i++) push(mk(100 + i));
    repeat (8) cycle();
    chk("bp_rden_pulses", CMD_W'(rden_cnt), CMD_W'(2));
    chk("bp_valid", CMD_W'(cmd_if.cmd_valid), CMD_W'(1));
    chk("bp_no_xfer", CMD_W'(xfer_cnt), CMD_W'(0));
    cmd_if.cmd_ready = 1'b1;
    for (int n = 0; n < 30 && xfer_cnt < 5; n++) cycle();
    chk("bp_xfers", CMD_W'(xfer_cnt), CMD_W'(5));
    chk("bp_sb_empty", CMD_W'(sb.size()), CMD_W'(0));

    // empty rises right after a read: in-flight word still delivered
    xfer_cnt = 0;
    push(mk(200));
    push(mk(201));
    for (int n = 0; n < 10 && !s_rden; n++) cycle();
    hold_empty = 1'b1;
    rden_cnt = 0;
    repeat (5) cycle();
    chk("empty_no_rden", CMD_W'(rden_cnt), CMD_W'(0));
    chk("empty_inflight_xfer", CMD_W'(xfer_cnt), CMD_W'(1));
    hold_empty = 1'b0;
    for (int n = 0; n < 10 && xfer_cnt < 2; n++) cycle();
    chk("empty_resume_xfer", CMD_W'(xfer_cnt), CMD_W'(2));

    // en dropped with one buffered and one in flight
    cmd_if.cmd_ready = 1'b0;
    xfer_cnt = 0;
    for (int i = 0; i < 4; i++) push(mk(300 + i));
    repeat (2) cycle();
    en = 1'b0;
    rden_cnt = 0;
    cmd_if.cmd_ready = 1'b1;
    repeat (6) cycle();
    chk("en_off_xfers", CMD_W'(xfer_cnt), CMD_W'(2));
    chk("en_off_no_rden", CMD_W'(rden_cnt), CMD_W'(0));
    chk("en_off_idle", CMD_W'(busy), CMD_W'(0));

    // refill to occ=2 then reset mid-operation
    cmd_if.cmd_ready = 1'b0;
    en = 1'b1;
    rden_cnt = 0;
    repeat (4) cycle();
    chk("refill_rden", CMD_W'(rden_cnt), CMD_W'(2));
    chk("refill_valid", CMD_W'(cmd_if.cmd_valid), CMD_W'(1));
    rstn = 1'b0;
    #1;
    chk("midrst_valid", CMD_W'(cmd_if.cmd_valid), CMD_W'(0));
    chk("midrst_cnt", CMD_W'(cmd_cnt), CMD_W'(0));
    chk("midrst_busy", CMD_W'(busy), CMD_W'(0));
    chk("midrst_rden", CMD_W'(fifo_rden), CMD_W'(0));
    sb.delete();
    prev_hold = 1'b0;
    cycle();
    rstn = 1'b1;
    repeat (3) cycle();
    chk("post_rst_valid", CMD_W'(cmd_if.cmd_valid), CMD_W'(0));
    chk("fifo_underflow", CMD_W'(underflow), CMD_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
